// File: rtl/ipsxe_floating_point_hi_carry_resolve_v1_0.sv
// Carry-resolve stage: adds a signed carry word to an unsigned high segment
// per channel, with wrap or clamp, overflow/underflow flags and a CE pipeline.
module ipsxe_floating_point_hi_carry_resolve_v1_0 #(
   parameter int HI_WIDTH  = 8,
   parameter int CIN_WIDTH = 5,
   parameter int CH_NUM    = 1,
   parameter int LATENCY   = 1,
   parameter int SAT_MODE  = 0
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_ce,
   input  logic                         i_valid,
   input  logic [CH_NUM*HI_WIDTH-1:0]   i_hi,
   input  logic [CH_NUM*CIN_WIDTH-1:0]  i_cin,
   output logic                         o_valid,
   output logic [CH_NUM*HI_WIDTH-1:0]   o_sum,
   output logic [CH_NUM-1:0]            o_ovf,
   output logic [CH_NUM-1:0]            o_unf
);

   localparam int XW  = HI_WIDTH + 2;
   localparam int SW  = CH_NUM * HI_WIDTH;
   localparam int STG = (LATENCY < 1) ? 1 : LATENCY;

   logic [SW-1:0]          sum_c;
   logic [CH_NUM-1:0]      ovf_c;
   logic [CH_NUM-1:0]      unf_c;
   logic signed [XW-1:0]   hi_x;
   logic signed [XW-1:0]   cin_x;
   logic signed [XW-1:0]   ex_x;

   // Two guard bits keep hi + most-negative cin from wrapping internally.
   always_comb begin
      sum_c = '0;
      ovf_c = '0;
      unf_c = '0;
      hi_x  = '0;
      cin_x = '0;
      ex_x  = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         hi_x  = {2'b00, i_hi[k*HI_WIDTH +: HI_WIDTH]};
         cin_x = {{(XW-CIN_WIDTH){i_cin[k*CIN_WIDTH+CIN_WIDTH-1]}},
                  i_cin[k*CIN_WIDTH +: CIN_WIDTH]};
         ex_x  = hi_x + cin_x;
         unf_c[k] = ex_x[XW-1];
         ovf_c[k] = ~ex_x[XW-1] & ex_x[HI_WIDTH];
         if (SAT_MODE != 0 && ovf_c[k]) begin
            sum_c[k*HI_WIDTH +: HI_WIDTH] = '1;
         end else if (SAT_MODE != 0 && unf_c[k]) begin
            sum_c[k*HI_WIDTH +: HI_WIDTH] = '0;
         end else begin
            sum_c[k*HI_WIDTH +: HI_WIDTH] = ex_x[HI_WIDTH-1:0];
         end
      end
   end

   generate
      if (LATENCY == 0) begin : g_comb
         logic unused_ctl;
         assign unused_ctl = ^{i_clk, i_rst, i_ce};
         assign o_valid = i_valid;
         assign o_sum   = sum_c;
         assign o_ovf   = ovf_c;
         assign o_unf   = unf_c;
      end else begin : g_pipe
         logic [STG-1:0]             vld_q, vld_d;
         logic [STG-1:0][SW-1:0]     sum_q, sum_d;
         logic [STG-1:0][CH_NUM-1:0] ovf_q, ovf_d;
         logic [STG-1:0][CH_NUM-1:0] unf_q, unf_d;

         always_comb begin
            vld_d = vld_q;
            sum_d = sum_q;
            ovf_d = ovf_q;
            unf_d = unf_q;
            if (i_ce) begin
               vld_d[0] = i_valid;
               sum_d[0] = sum_c;
               ovf_d[0] = ovf_c;
               unf_d[0] = unf_c;
               for (int s = 1; s < STG; s++) begin
                  vld_d[s] = vld_q[s-1];
                  sum_d[s] = sum_q[s-1];
                  ovf_d[s] = ovf_q[s-1];
                  unf_d[s] = unf_q[s-1];
               end
            end
         end

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               vld_q <= '0;
               sum_q <= '0;
               ovf_q <= '0;
               unf_q <= '0;
            end else begin
               vld_q <= vld_d;
               sum_q <= sum_d;
               ovf_q <= ovf_d;
               unf_q <= unf_d;
            end
         end

         assign o_valid = vld_q[STG-1];
         assign o_sum   = sum_q[STG-1];
         assign o_ovf   = ovf_q[STG-1];
         assign o_unf   = unf_q[STG-1];
      end
   endgenerate

endmodule
